rd_burst_arbiter: RTL and testbench
===================================

Name: rd_burst_arbiter

Overview:
- Shares one buffer read port between N_CH strobe-driven consumers (UART/telemetry frame channels).
- On each accepted strobe, the block runs a WORDS-word read burst with one paced RD pulse per word.
- One channel owns the port at a time; ownership rotates round-robin, never fixed priority.
- Sits between the per-channel frame strobes and the shared receive-buffer RAM. Drives a single address bus plus a one-hot grant instead of per-channel tri-stated addresses.

Parameters:
- N_CH, 5, number of requesting channels.
- WORDS, 18, words read per burst (addresses 0..WORDS-1).
- SLOT_LEN, 64, clock cycles per word slot.
- RD_ON, 40, slot cycle index at which rd rises.
- RD_OFF, 44, slot cycle index at which rd falls (rd high for RD_OFF-RD_ON cycles).
- ADR_W, 5, read address width; requires WORDS <= 2**ADR_W.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- strob  in  N_CH  per-channel request strobes, asynchronous, level-held by source.
- grant  out  N_CH  one-hot owner of the read port; all-zero when idle.
- rd  out  1  buffer read strobe.
- rd_adr  out  ADR_W  buffer word address; 0 when grant is all-zero.
- busy  out  1  high while any burst is in progress.
- done  out  N_CH  one-cycle pulse on the owning channel's bit when its burst completes (write-side pointer reset).

Behaviour:
- Reset: when rst is high at a clk edge, the following are cleared: grant=0, rd=0, rd_adr=0, busy=0, done=0, synchronizers=0, armed=all-ones, rr_ptr=0, FSM=IDLE. This applies in any state, including mid-burst; the aborted burst produces no done pulse.
- Input sync: each strob bit passes through a 2-FF synchronizer, giving s_strob.
- Request: req[i] = s_strob[i] & armed[i].
- Re-arm:
  - armed[i] clears in the same cycle done[i] pulses.
  - armed[i] sets again on the first cycle s_strob[i]=0.
  - A strobe held high therefore yields exactly one burst.
- FSM states: IDLE, SLOT, ADV, FIN.
- IDLE:
  - If any req is set, pick the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N_CH-1, 0, ...).
  - Load grant one-hot, busy=1, word=0, slot_cnt=0, then go to SLOT.
  - Latency: strob edge to grant is 3 clk (2 sync + 1 arbitration).
- SLOT:
  - slot_cnt increments each cycle.
  - rd=1 exactly for the cycles where slot_cnt is in [RD_ON, RD_OFF-1], i.e. 4 cycles at default. rd is registered.
  - rd_adr = word throughout.
  - When slot_cnt == SLOT_LEN-1, go to ADV.
- ADV (1 cycle):
  - If word == WORDS-1, go to FIN.
  - Otherwise word += 1, slot_cnt=0, go to SLOT.
- FIN (1 cycle):
  - done[owner]=1, armed[owner]=0, rr_ptr = owner+1 (wraps N_CH-1 to 0).
  - grant=0, busy=0, rd_adr=0, go to IDLE.
  - A new grant can be issued no earlier than the cycle after FIN.
- Burst length: (SLOT_LEN+1)*WORDS cycles from grant to FIN. At default, 65*18 = 1170.
- Strobe drop mid-burst: the burst still completes. armed is set on drop, and done still clears it; the source must release and re-assert to request again.
- Simultaneous requests: round-robin order resolves them; requests that lose are held until served.
- Invariants:
  - grant is one-hot or zero.
  - rd=1 implies busy=1.
  - rd_adr < WORDS always.
  - done is never set on two bits at once.

Decomposition:
- Shared package (frame_pkg):
  - FSM state enum (IDLE/SLOT/ADV/FIN).
  - Default constants N_CH=5, WORDS=18, SLOT_LEN=64, RD_ON=40, RD_OFF=44.
  - These defaults are shared with the write-side and frame-builder blocks.
- One sub-module, rr_pick: combinational round-robin first-one finder. Inputs are req and rr_ptr; outputs are a one-hot pick and a valid flag. It is reused by the write-side arbiter.

Test Plan:
- Single request: strob[2]=1 from cycle 0.
  - Grant=00100 at cycle 3.
  - 18 rd pulses, each 4 cycles wide, rising at offsets 40 within each 65-cycle word period.
  - rd_adr steps 0..17.
  - done[2] single pulse at cycle 3+1170; busy low after it.
- Held strobe: keep strob[2]=1 after done.
  - No second grant.
  - Drop for 5 cycles and raise again: new burst granted 3 cycles after the raise.
- Simultaneous strob[0] and strob[3] after reset: grant order ch0 then ch3, with ch3 granted one cycle after done[0].
- All five strobes held high: grants 0,1,2,3,4 in sequence, then idle. Pulse strob[1] low/high during ch4's burst: ch1 granted next.
- Reset mid-burst: assert rst for 1 cycle at word 7, slot_cnt 30.
  - Next cycle: grant=0, rd=0, rd_adr=0, busy=0, no done pulse.
  - Re-request on ch4 starts at address 0, and the pointer search starts from ch0.
- Glitch: strob[1] high for 1 clk while idle → grant may occur. strob[1] sampled high only between edges (no setup-violating edge) → no grant. Check grant one-hot, rd/busy invariant, and rd_adr<18 on every cycle of all tests.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared constants and types for the frame read/write arbiters and frame builder.
package frame_pkg;

    localparam int N_CH_DEF     = 5;
    localparam int WORDS_DEF    = 18;
    localparam int SLOT_LEN_DEF = 64;
    localparam int RD_ON_DEF    = 40;
    localparam int RD_OFF_DEF   = 44;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT = 2'd1,
        ADV  = 2'd2,
        FIN  = 2'd3
    } arb_state_t;

    // Index of the set bit of a one-hot vector (0 when the vector is empty).
    function automatic int onehot_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-one finder: lowest set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N     = 5,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             valid
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   first;
    logic [2*N-1:0] back;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        first = rot & ((~rot) + N'(1));
        back  = {first, first} << ptr;
        pick  = back[2*N-1:N];
    end

    assign valid = |req;

endmodule

// File: rtl/rd_burst_arbiter.sv
// Shared receive-buffer read port arbiter: round-robin ownership, one paced
// WORDS-word read burst per accepted channel strobe.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// SLOT  | word slot running, slot_cnt counting, rd pulsed mid-slot
// ADV   | end of a word slot; step address or finish
// FIN   | done pulse on owner, pointer moved past it; arbitrate again
module rd_burst_arbiter
    import frame_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int WORDS    = WORDS_DEF,
    parameter int SLOT_LEN = SLOT_LEN_DEF,
    parameter int RD_ON    = RD_ON_DEF,
    parameter int RD_OFF   = RD_OFF_DEF,
    parameter int ADR_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   strob,
    output logic [N_CH-1:0]   grant,
    output logic              rd,
    output logic [ADR_W-1:0]  rd_adr,
    output logic              busy,
    output logic [N_CH-1:0]   done
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SC_W  = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

    localparam logic [SC_W-1:0]  SLOT_LAST = SC_W'(SLOT_LEN - 1);
    localparam logic [SC_W:0]    RD_ON_C   = (SC_W + 1)'(RD_ON);
    localparam logic [SC_W:0]    RD_OFF_C  = (SC_W + 1)'(RD_OFF);
    localparam logic [ADR_W-1:0] WORD_LAST = ADR_W'(WORDS - 1);

    logic [N_CH-1:0]  sync_1;
    logic [N_CH-1:0]  s_strob;
    logic [N_CH-1:0]  armed;
    logic [N_CH-1:0]  armed_nx;
    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  pick;
    logic             pick_valid;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_nx;

    arb_state_t       state;
    arb_state_t       state_nx;
    logic [ADR_W-1:0] word;
    logic [ADR_W-1:0] word_nx;
    logic [SC_W-1:0]  slot_cnt;
    logic [SC_W-1:0]  slot_nx;

    logic [N_CH-1:0]  grant_nx;
    logic             rd_nx;
    logic [ADR_W-1:0] rd_adr_nx;
    logic             busy_nx;
    logic [N_CH-1:0]  done_nx;
    int               owner;

    assign req = s_strob & armed;

    rr_pick #(
        .N     (N_CH),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    // Two-flop synchronizer for the asynchronous channel strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1  <= '0;
            s_strob <= '0;
        end else begin
            sync_1  <= strob;
            s_strob <= sync_1;
        end
    end

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        busy_nx   = busy;
        rd_adr_nx = rd_adr;
        word_nx   = word;
        slot_nx   = slot_cnt;
        rr_ptr_nx = rr_ptr;
        done_nx   = '0;
        owner     = onehot_idx(32'(grant));
        // A released strobe re-arms its channel; a finishing burst disarms it.
        armed_nx  = armed | ~s_strob;

        case (state)
            IDLE, FIN: begin
                // FIN already sees the moved pointer and cleared arm bit, so
                // the next owner can be granted in the cycle after FIN.
                if (pick_valid) begin
                    grant_nx  = pick;
                    busy_nx   = 1'b1;
                    word_nx   = '0;
                    slot_nx   = '0;
                    rd_adr_nx = '0;
                    state_nx  = SLOT;
                end else begin
                    state_nx  = IDLE;
                end
            end
            SLOT: begin
                slot_nx = slot_cnt + 1'b1;
                if (slot_cnt == SLOT_LAST) begin
                    state_nx = ADV;
                end
            end
            ADV: begin
                if (word == WORD_LAST) begin
                    done_nx   = grant;
                    armed_nx  = armed_nx & ~grant;
                    rr_ptr_nx = (owner >= N_CH - 1) ? '0 : PTR_W'(owner + 1);
                    grant_nx  = '0;
                    busy_nx   = 1'b0;
                    rd_adr_nx = '0;
                    word_nx   = '0;
                    state_nx  = FIN;
                end else begin
                    word_nx   = word + 1'b1;
                    rd_adr_nx = word + 1'b1;
                    slot_nx   = '0;
                    state_nx  = SLOT;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // rd tracks the slot counter it will be registered alongside.
        rd_nx = (state_nx == SLOT) &&
                ({1'b0, slot_nx} >= RD_ON_C) &&
                ({1'b0, slot_nx} <  RD_OFF_C);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            rd       <= 1'b0;
            rd_adr   <= '0;
            busy     <= 1'b0;
            done     <= '0;
            armed    <= '1;
            rr_ptr   <= '0;
            word     <= '0;
            slot_cnt <= '0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            rd       <= rd_nx;
            rd_adr   <= rd_adr_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            armed    <= armed_nx;
            rr_ptr   <= rr_ptr_nx;
            word     <= word_nx;
            slot_cnt <= slot_nx;
        end
    end

endmodule

// File: tb/tb_rd_burst_arbiter.sv
// Scoreboard bench for rd_burst_arbiter: stimulus queues grant/done events,
// a monitor pops them as the DUT shows them and checks every burst cycle.
module tb_rd_burst_arbiter;

    localparam int N      = 5;
    localparam int WORDS  = 18;
    localparam int PERIOD = 65;          // 64 slot cycles + 1 advance cycle
    localparam int BURST  = 1170;        // PERIOD * WORDS, grant to done
    localparam int LAT    = 3;           // strobe to grant

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] strob = '0;
    logic [N-1:0] grant;
    logic         rd;
    logic [4:0]   rd_adr;
    logic         busy;
    logic [N-1:0] done;

    typedef struct {
        int kind;   // 0 = grant, 1 = done
        int ch;
        int cyc;
    } ev_t;

    ev_t expq[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;

    rd_burst_arbiter #(
        .N_CH     (5),
        .WORDS    (18),
        .SLOT_LEN (64),
        .RD_ON    (40),
        .RD_OFF   (44),
        .ADR_W    (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .strob  (strob),
        .grant  (grant),
        .rd     (rd),
        .rd_adr (rd_adr),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic int ch_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_event(input int kind, input int ch);
        ev_t e;
        if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_%s: got ch%0d at cycle %0d, expected no event",
                     (kind == 0) ? "grant" : "done", ch, cyc);
        end else begin
            e = expq.pop_front();
            check("event_kind", kind, e.kind);
            check("event_ch", ch, e.ch);
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    task automatic push(input int kind, input int ch, input int c);
        ev_t e;
        e.kind = kind;
        e.ch   = ch;
        e.cyc  = c;
        expq.push_back(e);
    endtask

    // Queue a full burst for channel ch granted at cycle g.
    task automatic push_burst(input int ch, input int g);
        push(0, ch, g);
        push(1, ch, g + BURST);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin : monitor
        logic [N-1:0] prev_grant;
        int act, g_cyc, g_own, off, w, s;
        prev_grant = '0;
        act = 0;
        g_cyc = 0;
        g_own = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                check("reset_outputs", int'({grant, rd, rd_adr, busy, done}), 0);
                act = 0;
                prev_grant = '0;
            end else begin
                check("invariants",
                      int'($onehot0(grant) && (!rd || busy) && (rd_adr < WORDS) && $onehot0(done)), 1);
                if (grant != '0 && grant != prev_grant) begin
                    check_event(0, ch_of(grant));
                    act = 1;
                    g_cyc = cyc;
                    g_own = ch_of(grant);
                end
                if (act != 0) begin
                    off = cyc - g_cyc;
                    if (off < BURST) begin
                        w = off / PERIOD;
                        s = off % PERIOD;
                        check("rd", int'(rd), int'(s >= 40 && s <= 43));
                        check("rd_adr", int'(rd_adr), w);
                        check("busy", int'(busy), 1);
                        check("grant_hold", int'(grant), 1 << g_own);
                    end else begin
                        act = 0;
                        check("fin_outputs", int'({grant, rd, rd_adr, busy}), 0);
                    end
                end else begin
                    check("idle_outputs", int'({grant, rd, rd_adr, busy}), 0);
                end
                if (done != '0) begin
                    check_event(1, ch_of(done));
                end
                prev_grant = grant;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation reached cycle %0d without finishing, expected under 20000", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r, g, g4, g1;
        rst = 1'b1;
        strob = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single request on ch2.
        @(negedge clk);
        r = cyc;
        strob[2] = 1'b1;
        g = r + LAT;
        push_burst(2, g);
        wait_until(g + BURST + 50);

        // Held strobe produced no second grant; drop 5 cycles and raise.
        strob[2] = 1'b0;
        wait_until(cyc + 5);
        strob[2] = 1'b1;
        r = cyc;
        g = r + LAT;
        push_burst(2, g);
        wait_until(g + BURST + 20);
        strob[2] = 1'b0;
        wait_until(cyc + 5);

        // Simultaneous ch0 and ch3 after reset: ch3 one cycle after done[0].
        pulse_reset();
        @(negedge clk);
        r = cyc;
        strob = 5'b01001;
        g = r + LAT;
        push_burst(0, g);
        push_burst(3, g + BURST + 1);
        wait_until(g + 2 * (BURST + 1) + 20);
        strob = '0;
        wait_until(cyc + 5);

        // All five held: 0..4 back to back; ch1 re-strobed during ch4.
        pulse_reset();
        @(negedge clk);
        r = cyc;
        strob = 5'b11111;
        g = r + LAT;
        for (int k = 0; k < N; k++) begin
            push_burst(k, g + k * (BURST + 1));
        end
        g4 = g + 4 * (BURST + 1);
        push_burst(1, g4 + BURST + 1);
        wait_until(g4 + 100);
        strob[1] = 1'b0;
        wait_until(g4 + 110);
        strob[1] = 1'b1;
        wait_until(g4 + 2 * (BURST + 1) + 20);
        strob = '0;
        wait_until(cyc + 5);

        // Reset at word 7, slot 30 of a ch3 burst; aborted burst has no done.
        @(negedge clk);
        r = cyc;
        strob[3] = 1'b1;
        g = r + LAT;
        push(0, 3, g);
        wait_until(g + 7 * PERIOD + 30);
        rst = 1'b1;
        strob[3] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_until(cyc + 5);
        // Pointer restarts at ch0, so ch1 beats ch4; ch4 then reads from 0.
        r = cyc;
        strob = 5'b10010;
        g1 = r + LAT;
        push_burst(1, g1);
        push_burst(4, g1 + BURST + 1);
        wait_until(g1 + 2 * (BURST + 1) + 20);
        strob = '0;
        wait_until(cyc + 5);

        // Pulse wholly between clock edges: never sampled, no grant.
        @(posedge clk);
        #2 strob[1] = 1'b1;
        #2 strob[1] = 1'b0;
        wait_until(cyc + 20);

        // One-clock pulse spanning an edge: sampled, granted.
        @(negedge clk);
        r = cyc;
        strob[1] = 1'b1;
        @(negedge clk);
        strob[1] = 1'b0;
        g = r + LAT;
        push_burst(1, g);
        wait_until(g + BURST + 20);

        while (expq.size() != 0) begin
            ev_t e;
            e = expq.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got nothing, expected kind %0d ch%0d at cycle %0d",
                     e.kind, e.ch, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
